// File: rtl/x_uart_tx.sv
// x_uart_tx: byte-wide UART transmitter (start, 8 data LSB first, stop) with a one-byte holding register.
// Define X_UART_TX_PARITY_EN to insert an even-parity bit between data bit 7 and stop.
module x_uart_tx #(
    parameter int CLK_HZ = 12_000_000,
    parameter int BAUD   = 115_200
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    output logic       o_ready,
    output logic       o_tx,
    output logic       o_busy
);
    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

    state_e           state_q, state_d;
    logic             hold_full_q, hold_full_d;
    logic [7:0]       hold_q, hold_d;
    logic [7:0]       shift_q, shift_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic             tx_q, tx_d;
    logic             bit_end;
    logic             accept;
    logic             load;
`ifdef X_UART_TX_PARITY_EN
    logic             par_q, par_d;
`endif

    always_comb begin
        state_d     = state_q;
        hold_full_d = hold_full_q;
        hold_d      = hold_q;
        shift_d     = shift_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        tx_d        = tx_q;
        load        = 1'b0;
        bit_end     = (baud_q == CNT_LAST);
        accept      = i_valid & ~hold_full_q;
`ifdef X_UART_TX_PARITY_EN
        par_d       = par_q;
`endif

        if (state_q != IDLE) begin
            baud_d = bit_end ? '0 : baud_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                load = hold_full_q;
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
`ifdef X_UART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = par_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end
            end
`ifdef X_UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    // A held byte chains straight into the next start bit.
                    if (hold_full_q) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase

        if (load) begin
            state_d     = START;
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            baud_d      = '0;
            tx_d        = 1'b0;
`ifdef X_UART_TX_PARITY_EN
            par_d       = ^hold_q;
`endif
        end

        // Accept needs an empty register, transfer a full one, so they never coincide.
        if (accept) begin
            hold_d      = i_data;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q     <= IDLE;
            hold_full_q <= 1'b0;
            baud_q      <= '0;
            bit_q       <= '0;
            tx_q        <= 1'b1;
        end else begin
            state_q     <= state_d;
            hold_full_q <= hold_full_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            tx_q        <= tx_d;
        end
    end

    always_ff @(posedge i_clk) begin
        hold_q  <= hold_d;
        shift_q <= shift_d;
`ifdef X_UART_TX_PARITY_EN
        par_q   <= par_d;
`endif
    end

    assign o_ready = ~hold_full_q;
    assign o_busy  = (state_q != IDLE) | hold_full_q;
    assign o_tx    = tx_q;

endmodule

// File: tb/tb_x_uart_tx.sv
// tb_x_uart_tx: directed bench for x_uart_tx; decodes the serial line at bit centres.
// Honours X_UART_TX_PARITY_EN for the frame layout.
module tb_x_uart_tx;
    localparam int C    = 104;
    localparam int HALF = C / 2;
`ifdef X_UART_TX_PARITY_EN
    localparam int FRAME = 11 * C;
`else
    localparam int FRAME = 10 * C;
`endif

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_valid = 1'b0;
    logic [7:0] i_data = 8'h00;
    logic       o_ready;
    logic       o_tx;
    logic       o_busy;

    x_uart_tx #(.CLK_HZ(12_000_000), .BAUD(115_200)) dut (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_valid(i_valid),
        .i_data (i_data),
        .o_ready(o_ready),
        .o_tx   (o_tx),
        .o_busy (o_busy)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    // line: data bits in transmit order, line[7] goes out first
    typedef struct {
        logic [7:0] data;
        logic [7:0] line;
        logic       par;
    } vec_t;

    vec_t tv[6];
    vec_t mon_exp[3];
    logic mon_rdy[3];
    int   st_cyc[3];
    int   acc_cyc;
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic send_one(input logic [7:0] d);
        i_data  = d;
        i_valid = 1'b1;
        acc_cyc = cyc;
        @(negedge i_clk);
        chk("accept_ready_low", {31'd0, o_ready}, 32'd0);
        i_valid = 1'b0;
        i_data  = ~d;
    endtask

    task automatic mon(input int n);
        int t;
        for (int f = 0; f < n; f++) begin
            t = 0;
            while (o_tx !== 1'b0 && t < 4000) begin
                @(negedge i_clk);
                t++;
            end
            if (t >= 4000) begin
                chk("mon_start_timeout", 32'(t), 32'd0);
                return;
            end
            st_cyc[f] = cyc;
            if (f > 0) chk($sformatf("f%0d_gap", f), 32'(st_cyc[f] - st_cyc[f-1]), 32'(FRAME));
            repeat (HALF) @(negedge i_clk);
            chk($sformatf("f%0d_start", f), {31'd0, o_tx}, 32'd0);
            for (int b = 0; b < 8; b++) begin
                repeat (C) @(negedge i_clk);
                chk($sformatf("f%0d_%0h_bit%0d", f, mon_exp[f].data, b),
                    {31'd0, o_tx}, {31'd0, mon_exp[f].line[7-b]});
            end
`ifdef X_UART_TX_PARITY_EN
            repeat (C) @(negedge i_clk);
            chk($sformatf("f%0d_parity", f), {31'd0, o_tx}, {31'd0, mon_exp[f].par});
`endif
            repeat (C) @(negedge i_clk);
            chk($sformatf("f%0d_stop", f), {31'd0, o_tx}, 32'd1);
            chk($sformatf("f%0d_ready_at_stop", f), {31'd0, o_ready}, {31'd0, mon_rdy[f]});
        end
        t = 0;
        while (o_busy !== 1'b0 && t < 2000) begin
            @(negedge i_clk);
            t++;
        end
        chk("busy_fall", 32'(cyc - st_cyc[0]), 32'(n * FRAME));
    endtask

    task automatic drive_seq(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic swap);
        logic [7:0] bs[3];
        int   k, t, w;
        logic rp;
        bs[0] = b0; bs[1] = b1; bs[2] = b2;
        k = 0; t = 0; w = 0;
        i_valid = 1'b1;
        i_data  = bs[0];
        rp      = o_ready;
        while (k < 3 && t < 10000) begin
            @(negedge i_clk);
            t++;
            if (rp) begin
                k++;
                if (k < 3) i_data = bs[k];
                else i_valid = 1'b0;
            end else if (swap && k == 2) begin
                w++;
                if (w == 300) begin
                    chk("bp_held_ready_low", {31'd0, o_ready}, 32'd0);
                    i_data = 8'h34;
                end
            end
            rp = o_ready;
        end
        i_valid = 1'b0;
        chk("drive_done", 32'(k), 32'd3);
    endtask

    task automatic rst_mid(input int offs, input logic exp_pre);
        int t = 0;
        int errs = 0;
        send_one(8'h3C);
        while (o_tx !== 1'b0 && t < 10) begin
            @(negedge i_clk);
            t++;
        end
        chk("rst_frame_start", {31'd0, o_tx}, 32'd0);
        repeat (offs) @(negedge i_clk);
        chk("rst_pre_tx", {31'd0, o_tx}, {31'd0, exp_pre});
        #3 i_rst = 1'b0;
        #1;
        chk("rst_async_tx", {31'd0, o_tx}, 32'd1);
        chk("rst_async_ready", {31'd0, o_ready}, 32'd1);
        chk("rst_async_busy", {31'd0, o_busy}, 32'd0);
        @(negedge i_clk);
        i_rst = 1'b1;
        repeat (3 * C) begin
            @(negedge i_clk);
            if (o_tx !== 1'b1 || o_ready !== 1'b1 || o_busy !== 1'b0) errs++;
        end
        chk("rst_no_frame", 32'(errs), 32'd0);
    endtask

    initial begin
        #600_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int errs;
        tv[0] = '{data: 8'hA5, line: 8'b10100101, par: 1'b0};
        tv[1] = '{data: 8'h01, line: 8'b10000000, par: 1'b1};
        tv[2] = '{data: 8'h03, line: 8'b11000000, par: 1'b0};
        tv[3] = '{data: 8'h80, line: 8'b00000001, par: 1'b1};
        tv[4] = '{data: 8'h3C, line: 8'b00111100, par: 1'b0};
        tv[5] = '{data: 8'h34, line: 8'b00101100, par: 1'b1};

        // reset and idle
        #12 i_rst = 1'b0;
        repeat (3) @(negedge i_clk);
        chk("rst_tx", {31'd0, o_tx}, 32'd1);
        chk("rst_ready", {31'd0, o_ready}, 32'd1);
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        i_rst = 1'b1;
        errs = 0;
        repeat (2000) begin
            @(negedge i_clk);
            if (o_tx !== 1'b1 || o_ready !== 1'b1 || o_busy !== 1'b0) errs++;
        end
        chk("idle_2000", 32'(errs), 32'd0);

        // single frames from idle
        for (int i = 0; i < 6; i++) begin
            mon_exp[0] = tv[i];
            mon_rdy[0] = 1'b1;
            fork
                send_one(tv[i].data);
                mon(1);
            join
            chk($sformatf("latency_%0h", tv[i].data), 32'(st_cyc[0] - acc_cyc), 32'd2);
        end

        // back-to-back with i_valid held high
        mon_exp[0] = '{data: 8'h00, line: 8'b00000000, par: 1'b0};
        mon_exp[1] = '{data: 8'hFF, line: 8'b11111111, par: 1'b0};
        mon_exp[2] = '{data: 8'h55, line: 8'b10101010, par: 1'b0};
        mon_rdy[0] = 1'b0; mon_rdy[1] = 1'b0; mon_rdy[2] = 1'b1;
        fork
            drive_seq(8'h00, 8'hFF, 8'h55, 1'b0);
            mon(3);
        join

        // backpressure: 0x12 offered while full, replaced by 0x34 before acceptance
        mon_exp[0] = '{data: 8'hFF, line: 8'b11111111, par: 1'b0};
        mon_exp[1] = '{data: 8'h55, line: 8'b10101010, par: 1'b0};
        mon_exp[2] = tv[5];
        fork
            drive_seq(8'hFF, 8'h55, 8'h12, 1'b1);
            mon(3);
        join

        // reset mid-frame: during start bit, then during data bit 3
        rst_mid(HALF, 1'b0);
        rst_mid(HALF + 4 * C, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
